// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the sequential FPU units: field widths, bias,
// canonical NaN, exception flag layout and the divider state encoding.
package fpu_pkg;
   localparam int          FP32_EXP_W     = 8;
   localparam int          FP32_MAN_W     = 23;
   localparam int          FP32_BIAS      = 127;
   localparam logic [31:0] FP32_CANON_NAN = 32'h7fc00000;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      DIVIDE,
      NORM,
      ROUND,
      DONE
   } fdiv_state_e;
endpackage

// File: rtl/fp_div_seq_if.sv
// Issue/result handshake between the FPU issue logic (master) and a
// sequential FP32 unit (slave).
//   in_valid/in_ready/a/b : operand pair handshake
//   kill                  : pipeline flush of the in-flight operation
//   out_valid/out_ack     : result handshake, result held until acknowledged
//   res/fflags            : quotient and {NV,DZ,OF,UF,NX}
interface fp_div_seq_if;
   import fpu_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        out_valid;
   logic        out_ack;
   logic [31:0] res;
   fflags_t     fflags;

   modport master (
      output in_valid, a, b, kill, out_ack,
      input  in_ready, out_valid, res, fflags
   );

   modport slave (
      input  in_valid, a, b, kill, out_ack,
      output in_ready, out_valid, res, fflags
   );
endinterface

// File: rtl/fp32_unpack.sv
// Combinational FP32 field splitter with flush-to-zero of denormals.
//   i_op      : fp32 operand
//   o_sign    : sign bit
//   o_exp     : biased exponent
//   o_mant    : 24-bit mantissa with hidden bit (0 when exponent is 0)
//   o_is_zero : exponent 0 (zero or flushed denormal)
//   o_is_inf  : infinity
//   o_is_nan  : any NaN
//   o_is_snan : signalling NaN (quiet bit clear)
module fp32_unpack
   import fpu_pkg::*;
(
   input  logic [31:0]           i_op,
   output logic                  o_sign,
   output logic [FP32_EXP_W-1:0] o_exp,
   output logic [FP32_MAN_W:0]   o_mant,
   output logic                  o_is_zero,
   output logic                  o_is_inf,
   output logic                  o_is_nan,
   output logic                  o_is_snan
);
   logic [FP32_MAN_W-1:0] w_frac;
   logic                  w_exp_max;

   assign o_sign    = i_op[31];
   assign o_exp     = i_op[30:23];
   assign w_frac    = i_op[22:0];
   assign w_exp_max = &o_exp;
   assign o_is_zero = (o_exp == '0);
   assign o_mant    = o_is_zero ? '0 : {1'b1, w_frac};
   assign o_is_inf  = w_exp_max & (w_frac == '0);
   assign o_is_nan  = w_exp_max & (w_frac != '0);
   assign o_is_snan = o_is_nan & ~w_frac[FP32_MAN_W-1];
endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle FP32 divider (restoring, one quotient bit per cycle, RNE,
// denormals flushed to zero). Result is held until the issuer acknowledges.
//   g_clk, g_rst : clock, asynchronous active-high reset
//   bus          : slave side of fp_div_seq_if (operands in, result out)
//
// state  | meaning
// IDLE   | in_ready=1, waiting for an operand pair
// UNPACK | split operands, resolve special cases
// DIVIDE | one restoring quotient bit per cycle, QBITS cycles
// NORM   | shift left once if the quotient has no integer bit
// ROUND  | round-to-nearest-even, overflow/underflow resolution
// DONE   | out_valid=1, result held until out_ack
module fp_div_seq
   import fpu_pkg::*;
#(
   parameter int          QBITS     = 26,
   parameter logic [31:0] CANON_NAN = FP32_CANON_NAN
) (
   input  logic          g_clk,
   input  logic          g_rst,
   fp_div_seq_if.slave   bus
);
   localparam int CNT_W = $clog2(QBITS);

   fdiv_state_e             r_state;
   fdiv_state_e             w_state_nxt;
   logic [31:0]             r_a;
   logic [31:0]             r_b;
   logic                    r_sign;
   logic signed [9:0]       r_exp;
   logic [24:0]             r_rem;
   logic [23:0]             r_mb;
   logic [QBITS-1:0]        r_q;
   logic [CNT_W-1:0]        r_cnt;
   logic [31:0]             r_res;
   fflags_t                 r_flags;

   logic                    w_accept;
   logic                    w_in_ready;
   logic                    w_out_valid;

   logic                    w_sa, w_sb;
   logic [FP32_EXP_W-1:0]   w_ea, w_eb;
   logic [FP32_MAN_W:0]     w_ma, w_mb;
   logic                    w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sna, w_snb;

   logic                    w_special;
   logic [31:0]             w_spec_res;
   fflags_t                 w_spec_flags;
   logic                    w_sign;

   logic                    w_ge;
   logic [24:0]             w_rem_sub;

   logic [23:0]             w_mant;
   logic                    w_guard;
   logic                    w_rs;
   logic                    w_inc;
   logic [24:0]             w_sum;
   logic signed [9:0]       w_exp_rnd;
   logic [22:0]             w_frac;
   logic [31:0]             w_rnd_res;
   fflags_t                 w_rnd_flags;

   fp32_unpack u_unpack_a (
      .i_op      (r_a),
      .o_sign    (w_sa),
      .o_exp     (w_ea),
      .o_mant    (w_ma),
      .o_is_zero (w_za),
      .o_is_inf  (w_ia),
      .o_is_nan  (w_na),
      .o_is_snan (w_sna)
   );

   fp32_unpack u_unpack_b (
      .i_op      (r_b),
      .o_sign    (w_sb),
      .o_exp     (w_eb),
      .o_mant    (w_mb),
      .o_is_zero (w_zb),
      .o_is_inf  (w_ib),
      .o_is_nan  (w_nb),
      .o_is_snan (w_snb)
   );

   assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.kill;
   assign w_sign   = w_sa ^ w_sb;

   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = UNPACK;
         UNPACK:  w_state_nxt = w_special ? DONE : DIVIDE;
         DIVIDE:  if (r_cnt == CNT_W'(QBITS-1)) w_state_nxt = NORM;
         NORM:    w_state_nxt = ROUND;
         ROUND:   w_state_nxt = DONE;
         DONE:    if (bus.out_ack) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // kill beats out_ack; in IDLE it only blocks the accept (see w_accept)
      if (bus.kill && (r_state != IDLE)) w_state_nxt = IDLE;
   end

   always_comb begin
      w_in_ready  = (r_state == IDLE);
      w_out_valid = (r_state == DONE);
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.res       = r_res;
   assign bus.fflags    = r_flags;

   // Special-case priority: NaN-producing cases, then inf dividend (inf/0 is
   // plain inf without DZ), then finite/0, then zero results.
   always_comb begin
      w_special    = 1'b1;
      w_spec_res   = '0;
      w_spec_flags = '0;
      if (w_na || w_nb || (w_za && w_zb) || (w_ia && w_ib)) begin
         w_spec_res      = CANON_NAN;
         w_spec_flags.nv = w_sna | w_snb | (w_za & w_zb) | (w_ia & w_ib);
      end else if (w_ia) begin
         w_spec_res = {w_sign, 8'hff, 23'h0};
      end else if (w_zb) begin
         w_spec_res      = {w_sign, 8'hff, 23'h0};
         w_spec_flags.dz = 1'b1;
      end else if (w_za || w_ib) begin
         w_spec_res = {w_sign, 31'h0};
      end else begin
         w_special = 1'b0;
      end
   end

   // Remainder stays below 2*mb, so after a subtract it fits in 24 bits.
   assign w_ge      = (r_rem >= {1'b0, r_mb});
   assign w_rem_sub = r_rem - {1'b0, r_mb};

   // Quotient layout after NORM: 24 mantissa bits, guard, then round/extra
   // bits which only matter together with the remainder as sticky.
   assign w_mant    = r_q[QBITS-1 -: 24];
   assign w_guard   = r_q[QBITS-25];
   assign w_rs      = (|r_q[QBITS-26:0]) | (|r_rem);
   assign w_inc     = w_guard & (w_rs | w_mant[0]);
   assign w_sum     = {1'b0, w_mant} + {24'd0, w_inc};
   assign w_exp_rnd = r_exp + (w_sum[24] ? 10'sd1 : 10'sd0);
   assign w_frac    = w_sum[24] ? w_sum[23:1] : w_sum[22:0];

   always_comb begin
      w_rnd_flags = '0;
      if (w_exp_rnd >= 10'sd255) begin
         w_rnd_res      = {r_sign, 8'hff, 23'h0};
         w_rnd_flags.of = 1'b1;
         w_rnd_flags.nx = 1'b1;
      end else if (w_exp_rnd <= 10'sd0) begin
         w_rnd_res      = {r_sign, 31'h0};
         w_rnd_flags.uf = 1'b1;
         w_rnd_flags.nx = 1'b1;
      end else begin
         w_rnd_res      = {r_sign, w_exp_rnd[7:0], w_frac};
         w_rnd_flags.nx = w_guard | w_rs;
      end
   end

   always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_rem   <= '0;
         r_mb    <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_flags <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a <= bus.a;
                  r_b <= bus.b;
               end
            end
            UNPACK: begin
               r_sign <= w_sign;
               r_exp  <= $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                         + $signed(10'(FP32_BIAS));
               r_rem  <= {1'b0, w_ma};
               r_mb   <= w_mb;
               r_q    <= '0;
               r_cnt  <= '0;
               if (w_special && !bus.kill) begin
                  r_res   <= w_spec_res;
                  r_flags <= w_spec_flags;
               end
            end
            DIVIDE: begin
               r_rem <= w_ge ? {w_rem_sub[23:0], 1'b0} : {r_rem[23:0], 1'b0};
               r_q   <= {r_q[QBITS-2:0], w_ge};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            NORM: begin
               if (!r_q[QBITS-1]) begin
                  r_q   <= {r_q[QBITS-2:0], 1'b0};
                  r_exp <= r_exp - 10'sd1;
               end
            end
            ROUND: begin
               if (!bus.kill) begin
                  r_res   <= w_rnd_res;
                  r_flags <= w_rnd_flags;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_div_seq.sv
module tb_fp_div_seq;
   import fpu_pkg::*;

   logic g_clk = 1'b0;
   logic g_rst;
   int   checks   = 0;
   int   failures = 0;

   fp_div_seq_if bus();

   fp_div_seq dut (
      .g_clk (g_clk),
      .g_rst (g_rst),
      .bus   (bus)
   );

   always #5 g_clk = ~g_clk;

   task automatic issue(input logic [31:0] av, input logic [31:0] bv);
      @(negedge g_clk);
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      @(posedge g_clk);
   endtask

   // Counts negedges after the accept edge until out_valid is seen; -1 on timeout.
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge g_clk);
         bus.in_valid = 1'b0;
         lat++;
         if (bus.out_valid) break;
      end
      if (!bus.out_valid) lat = -1;
   endtask

   task automatic do_ack();
      bus.out_ack = 1'b1;
      @(posedge g_clk);
      @(negedge g_clk);
      bus.out_ack = 1'b0;
   endtask

   task automatic test_reset();
      g_rst = 1'b1;
      repeat (2) @(negedge g_clk);
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.res !== 32'h0) begin failures++; $display("FAIL reset_res got=%h exp=00000000", bus.res); end
      checks++; if (bus.fflags !== 5'h0) begin failures++; $display("FAIL reset_fflags got=%b exp=00000", bus.fflags); end
      g_rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      issue(32'h40C00000, 32'h40000000);
      wait_valid(lat);
      checks++; if (lat !== 30) begin failures++; $display("FAIL basic_latency got=%0d exp=30", lat); end
      checks++; if (bus.res !== 32'h40400000) begin failures++; $display("FAIL basic_res got=%h exp=40400000", bus.res); end
      checks++; if (bus.fflags !== 5'h00) begin failures++; $display("FAIL basic_fflags got=%b exp=00000", bus.fflags); end
      do_ack();
   endtask

   task automatic test_hold();
      int lat;
      issue(32'h3F800000, 32'h40400000);
      wait_valid(lat);
      checks++; if (lat !== 30) begin failures++; $display("FAIL hold_latency got=%0d exp=30", lat); end
      checks++; if (bus.res !== 32'h3EAAAAAB) begin failures++; $display("FAIL hold_res got=%h exp=3EAAAAAB", bus.res); end
      checks++; if (bus.fflags !== 5'h01) begin failures++; $display("FAIL hold_fflags got=%b exp=00001", bus.fflags); end
      for (int k = 0; k < 5; k++) begin
         @(negedge g_clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.res !== 32'h3EAAAAAB) begin
            failures++;
            $display("FAIL hold_stable cyc=%0d got valid=%b res=%h exp valid=1 res=3EAAAAAB", k, bus.out_valid, bus.res);
         end
      end
      do_ack();
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_ack got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid); end
   endtask

   task automatic test_kill();
      int lat;
      int seen;
      issue(32'h40C00000, 32'h40000000);
      @(negedge g_clk);
      bus.in_valid = 1'b0;
      repeat (11) @(posedge g_clk);
      @(negedge g_clk);
      bus.kill = 1'b1;
      @(posedge g_clk);
      @(negedge g_clk);
      bus.kill = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL kill_idle got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid); end
      checks++; if (bus.res !== 32'h3EAAAAAB || bus.fflags !== 5'h01) begin failures++; $display("FAIL kill_hold got res=%h fl=%b exp res=3EAAAAAB fl=00001", bus.res, bus.fflags); end
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge g_clk);
         if (bus.out_valid || !bus.in_ready) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL kill_quiet got busy_cycles=%0d exp=0", seen); end
      // kill in IDLE blocks the accept
      @(negedge g_clk);
      bus.in_valid = 1'b1; bus.kill = 1'b1;
      bus.a = 32'h40C00000; bus.b = 32'h40000000;
      @(posedge g_clk);
      @(negedge g_clk);
      bus.in_valid = 1'b0; bus.kill = 1'b0;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL kill_in_idle got ready=%b exp=1", bus.in_ready); end
      issue(32'h40800000, 32'h40000000);
      wait_valid(lat);
      checks++; if (lat !== 30) begin failures++; $display("FAIL kill_next_latency got=%0d exp=30", lat); end
      checks++; if (bus.res !== 32'h40000000 || bus.fflags !== 5'h00) begin failures++; $display("FAIL kill_next got res=%h fl=%b exp res=40000000 fl=00000", bus.res, bus.fflags); end
      do_ack();
   endtask

   task automatic test_specials();
      logic [31:0] va [4] = '{32'h3F800000, 32'h00000000, 32'h7F800001, 32'hFF800000};
      logic [31:0] vb [4] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h40000000};
      logic [31:0] vr [4] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000};
      logic [4:0]  vf [4] = '{5'b01000, 5'b10000, 5'b10000, 5'b00000};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(va[i], vb[i]);
         wait_valid(lat);
         checks++; if (lat !== 2) begin failures++; $display("FAIL special%0d_latency got=%0d exp=2", i, lat); end
         checks++; if (bus.res !== vr[i]) begin failures++; $display("FAIL special%0d_res got=%h exp=%h", i, bus.res, vr[i]); end
         checks++; if (bus.fflags !== vf[i]) begin failures++; $display("FAIL special%0d_fflags got=%b exp=%b", i, bus.fflags, vf[i]); end
         do_ack();
      end
   endtask

   task automatic test_ovf_unf();
      logic [31:0] va [2] = '{32'h7F7FFFFF, 32'h00800000};
      logic [31:0] vb [2] = '{32'h00800000, 32'h7F7FFFFF};
      logic [31:0] vr [2] = '{32'h7F800000, 32'h00000000};
      logic [4:0]  vf [2] = '{5'b00101, 5'b00011};
      int lat;
      for (int i = 0; i < 2; i++) begin
         issue(va[i], vb[i]);
         wait_valid(lat);
         checks++; if (lat !== 30) begin failures++; $display("FAIL range%0d_latency got=%0d exp=30", i, lat); end
         checks++; if (bus.res !== vr[i]) begin failures++; $display("FAIL range%0d_res got=%h exp=%h", i, bus.res, vr[i]); end
         checks++; if (bus.fflags !== vf[i]) begin failures++; $display("FAIL range%0d_fflags got=%b exp=%b", i, bus.fflags, vf[i]); end
         do_ack();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [4] = '{32'h40800000, 32'h3F800000, 32'hC0400000, 32'h3F800000};
      logic [31:0] vb [4] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h3FC00000};
      logic [31:0] vr [4] = '{32'h40000000, 32'h3EAAAAAB, 32'hC0000000, 32'h3F2AAAAB};
      logic [4:0]  vf [4] = '{5'b00000, 5'b00001, 5'b00000, 5'b00001};
      int lat;
      @(negedge g_clk);
      bus.in_valid = 1'b1; bus.a = va[0]; bus.b = vb[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge g_clk);
         wait_valid(lat);
         checks++; if (lat !== 30) begin failures++; $display("FAIL b2b%0d_latency got=%0d exp=30", i, lat); end
         checks++; if (bus.res !== vr[i] || bus.fflags !== vf[i]) begin failures++; $display("FAIL b2b%0d got res=%h fl=%b exp res=%h fl=%b", i, bus.res, bus.fflags, vr[i], vf[i]); end
         bus.out_ack = 1'b1;
         if (i < 3) begin
            bus.in_valid = 1'b1; bus.a = va[i+1]; bus.b = vb[i+1];
         end
         @(posedge g_clk);
         @(negedge g_clk);
         bus.out_ack = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      int lat;
      issue(32'h3F800000, 32'h40400000);
      @(negedge g_clk);
      bus.in_valid = 1'b0;
      repeat (5) @(posedge g_clk);
      #3 g_rst = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_ctrl got ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid); end
      checks++; if (bus.res !== 32'h0 || bus.fflags !== 5'h0) begin failures++; $display("FAIL arst_data got res=%h fl=%b exp res=00000000 fl=00000", bus.res, bus.fflags); end
      @(negedge g_clk);
      g_rst = 1'b0;
      issue(32'h40C00000, 32'h40000000);
      wait_valid(lat);
      checks++; if (lat !== 30 || bus.res !== 32'h40400000) begin failures++; $display("FAIL arst_recover got lat=%0d res=%h exp lat=30 res=40400000", lat, bus.res); end
      do_ack();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.kill     = 1'b0;
      bus.out_ack  = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      test_reset();
      test_basic();
      test_hold();
      test_kill();
      test_specials();
      test_ovf_unf();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
